// File: rtl/imem_prog.sv
// Programmable instruction memory: registered 1-cycle fetch in RUN, word loads in LOAD.
// state | meaning: RUN fetch from array; LOAD accept prog_we writes; FLUSH one idle cycle before RUN.
module imem_prog #(
  parameter int                 DATA_W = 32,
  parameter int                 ADDR_W = 6,
  parameter logic [DATA_W-1:0]  NOP    = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              fetch_en,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_fault,
  output logic              prog_busy,
  output logic [ADDR_W:0]   prog_count
);

  localparam int             DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // Contents survive rst; only the power-up value is defined.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP};

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              addr_fault_q, addr_fault_d;
  logic [ADDR_W:0]   prog_count_q, prog_count_d;
  logic              mem_we;
  logic [ADDR_W-1:0] rd_idx;
  logic              pc_bad;

  assign rd_idx = pc[ADDR_W+1:2];
  assign pc_bad = (pc[1:0] != 2'b00) || ((pc >> (ADDR_W + 2)) != 32'd0);

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    addr_fault_d = addr_fault_q;
    prog_count_d = prog_count_q;
    mem_we       = 1'b0;
    case (state_q)
      S_RUN: begin
        if (prog_en) begin
          state_d      = S_LOAD;
          inst_d       = NOP;
          inst_valid_d = 1'b0;
          addr_fault_d = 1'b0;
          prog_count_d = '0;
        end else if (fetch_en) begin
          inst_valid_d = 1'b1;
          addr_fault_d = pc_bad;
          inst_d       = pc_bad ? NOP : mem_q[rd_idx];
        end
      end
      S_LOAD: begin
        inst_d       = NOP;
        inst_valid_d = 1'b0;
        addr_fault_d = 1'b0;
        if (prog_we) begin
          mem_we = 1'b1;
          if (prog_count_q != CNT_MAX) prog_count_d = prog_count_q + 1'b1;
        end
        if (!prog_en) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        inst_d       = NOP;
        inst_valid_d = 1'b0;
        addr_fault_d = 1'b0;
        state_d      = S_RUN;
      end
      default: begin
        inst_d       = NOP;
        inst_valid_d = 1'b0;
        addr_fault_d = 1'b0;
        state_d      = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
      addr_fault_q <= 1'b0;
      prog_count_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      addr_fault_q <= addr_fault_d;
      prog_count_q <= prog_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[prog_addr] <= prog_data;
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign addr_fault = addr_fault_q;
  assign prog_count = prog_count_q;
  assign prog_busy  = (state_q == S_LOAD) || (state_q == S_FLUSH);

endmodule

// File: tb/tb_imem_prog.sv
// Bench for imem_prog: fetch expectations go through a scoreboard queue, checked 1ns after each rising edge.
module tb_imem_prog;

  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'd0;
  logic        fetch_en = 1'b1;
  logic        prog_en = 1'b0;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = 6'd0;
  logic [31:0] prog_data = 32'd0;

  logic [31:0] inst;
  logic        inst_valid, addr_fault, prog_busy;
  logic [6:0]  prog_count;

  logic [31:0] inst4;
  logic        inst_valid4, addr_fault4, prog_busy4;
  logic [4:0]  prog_count4;

  imem_prog u_dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .prog_en(prog_en),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .inst(inst), .inst_valid(inst_valid), .addr_fault(addr_fault),
    .prog_busy(prog_busy), .prog_count(prog_count)
  );

  imem_prog #(.ADDR_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .prog_en(prog_en),
    .prog_we(prog_we), .prog_addr(prog_addr[3:0]), .prog_data(prog_data),
    .inst(inst4), .inst_valid(inst_valid4), .addr_fault(addr_fault4),
    .prog_busy(prog_busy4), .prog_count(prog_count4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic        valid;
    logic        fault;
  } sb_t;

  sb_t         exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] model_mem [64];
  int          busy_cnt = 0;
  logic        busy_on = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] i, input logic v, input logic f);
    sb_t e;
    e.inst  = i;
    e.valid = v;
    e.fault = f;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drive(input logic [31:0] p, input logic fe, input logic pe, input logic we,
                       input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    pc = p; fetch_en = fe; prog_en = pe; prog_we = we; prog_addr = a; prog_data = d;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    drive(32'd0, 1'b1, 1'b1, 1'b1, a, d);
    model_mem[a] = d;
    expect_out("load_inst", NOP, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_t   e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_inst"},  {32'd0, inst},       {32'd0, e.inst});
      check({t, "_valid"}, {63'd0, inst_valid}, {63'd0, e.valid});
      check({t, "_fault"}, {63'd0, addr_fault}, {63'd0, e.fault});
    end
  end

  always @(negedge clk) if (busy_on && prog_busy) busy_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) model_mem[i] = NOP;

    repeat (2) @(negedge clk);
    check("rst_inst",  {32'd0, inst},       64'd0);
    check("rst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_fault", {63'd0, addr_fault}, 64'd0);
    check("rst_count", {57'd0, prog_count}, 64'd0);
    check("rst_busy",  {63'd0, prog_busy},  64'd0);

    @(negedge clk);
    rst = 1'b0; pc = 32'd0; fetch_en = 1'b1;
    expect_out("rst_fetch", model_mem[0], 1'b1, 1'b0);

    // Program words 0 and 1, then read them back.
    busy_cnt = 0; busy_on = 1'b1;
    drive(32'd0, 1'b1, 1'b1, 1'b0, 6'd0, 32'd0);
    expect_out("load_enter", NOP, 1'b0, 1'b0);
    wr(6'd0, 32'h00100443);
    wr(6'd1, 32'h00201025);
    drive(32'd0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("load_exit", NOP, 1'b0, 1'b0);
    drive(32'd0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("flush_nofetch", NOP, 1'b0, 1'b0);
    drive(32'd0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("load_rd0", 32'h00100443, 1'b1, 1'b0);
    busy_on = 1'b0;
    check("busy_cycles", 64'(busy_cnt), 64'd4);
    check("load_count", {57'd0, prog_count}, 64'd2);
    check("busy_run", {63'd0, prog_busy}, 64'd0);
    drive(32'd4, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("load_rd1", 32'h00201025, 1'b1, 1'b0);

    // Stall holds the last fetch.
    drive(32'd4, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("stall_pre", model_mem[1], 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(32'd8, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
      expect_out("stall_hold", model_mem[1], 1'b1, 1'b0);
    end
    drive(32'd8, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("stall_go", model_mem[2], 1'b1, 1'b0);

    // Illegal addresses.
    drive(32'h00000102, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("fault_misalign", NOP, 1'b1, 1'b1);
    drive(32'h00000100, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("fault_range", NOP, 1'b1, 1'b1);
    drive(32'd4, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("fault_hold", NOP, 1'b1, 1'b1);
    drive(32'h80000000, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("fault_msb", NOP, 1'b1, 1'b1);
    drive(32'd0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("fault_clear", model_mem[0], 1'b1, 1'b0);

    // prog_en wins over fetch_en; prog_we in RUN is ignored.
    drive(32'd4, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("prio_pre", model_mem[0], 1'b1, 1'b0);
    drive(32'd4, 1'b1, 1'b1, 1'b0, 6'd0, 32'd0);
    expect_out("prio", NOP, 1'b0, 1'b0);
    drive(32'd4, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("prio_exit", NOP, 1'b0, 1'b0);
    drive(32'd4, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("prio_flush", NOP, 1'b0, 1'b0);
    drive(32'd0, 1'b1, 1'b0, 1'b1, 6'd0, 32'hDEADBEEF);
    expect_out("we_in_run", model_mem[0], 1'b1, 1'b0);
    check("count_clr", {57'd0, prog_count}, 64'd0);
    drive(32'd0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("we_ignored", model_mem[0], 1'b1, 1'b0);

    // Reset in the middle of a load.
    drive(32'd0, 1'b1, 1'b1, 1'b0, 6'd0, 32'd0);
    expect_out("ml_enter", NOP, 1'b0, 1'b0);
    wr(6'd5, 32'h11110005);
    wr(6'd6, 32'h22220006);
    wr(6'd7, 32'h33330007);
    @(negedge clk);
    check("ml_count", {57'd0, prog_count}, 64'd3);
    rst = 1'b1; prog_en = 1'b0; prog_we = 1'b0;
    #1;
    check("ml_rst_valid", {63'd0, inst_valid}, 64'd0);
    check("ml_rst_count", {57'd0, prog_count}, 64'd0);
    check("ml_rst_busy",  {63'd0, prog_busy},  64'd0);
    check("ml_rst_inst",  {32'd0, inst},       {32'd0, NOP});
    @(negedge clk);
    rst = 1'b0; pc = 32'd20; fetch_en = 1'b1;
    expect_out("ml_rd5", model_mem[5], 1'b1, 1'b0);
    drive(32'd24, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("ml_rd6", model_mem[6], 1'b1, 1'b0);
    drive(32'd28, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("ml_rd7", model_mem[7], 1'b1, 1'b0);

    // 20 writes: 64-deep count reaches 20, 16-deep count saturates at 16.
    drive(32'd0, 1'b1, 1'b1, 1'b0, 6'd0, 32'd0);
    expect_out("sat_enter", NOP, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) wr(6'(i), 32'hA5000000 + 32'(i));
    drive(32'd0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("sat_exit", NOP, 1'b0, 1'b0);
    drive(32'd0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("sat_flush", NOP, 1'b0, 1'b0);
    drive(32'd76, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("sat_rd19", model_mem[19], 1'b1, 1'b0);
    check("sat_count6", {57'd0, prog_count},  64'd20);
    check("sat_count4", {59'd0, prog_count4}, 64'd16);
    check("sat_busy4",  {63'd0, prog_busy4},  64'd0);
    drive(32'd12, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    expect_out("sat_rd3", model_mem[3], 1'b1, 1'b0);
    check("a4_fault", {63'd0, addr_fault4}, 64'd1);
    drive(32'd12, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
    check("a4_rd3", {31'd0, inst_valid4, inst4}, {31'd0, 1'b1, 32'hA5000013});

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
